aes_serial_round_ctrl: RTL
==========================

# aes_serial_round_ctrl

Cycle sequencer for the byte-serial AES-128 encryption datapath: the 16-byte shift-register state file, its column MixColumns network and its ShiftRows permutation. Drives the state file's `en`, `doSR`, `doMC` controls, the plaintext-load select, the key-schedule step enable and the round constant. Handles the start/ready/done handshake with the host, and flags the output cycles in which the datapath emits ciphertext bytes. The block sits between the host interface and the `DataRegisters_Unit`/key-schedule pair. It holds no data.

## Interface
- `NR`, 10, number of AES rounds.
- `NB`, 16, bytes per state (shift cycles per phase).
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin one encryption; sampled only in IDLE.
- `abort` in 1: cancel current operation; present only with `AES_CTRL_ABORT_EN`.
- `ready` out 1: block idle, `start` will be accepted.
- `busy` out 1: inverse of `ready`.
- `en` out 1: datapath register enable; high in every non-IDLE state.
- `loadPT` out 1: datapath selects (plaintext byte XOR key byte) as `stateIn`; also the host plaintext read strobe.
- `doSR` out 1: ShiftRows cycle.
- `doMC` out 1: MixColumns column cycle.
- `keyEn` out 1: key schedule advances one byte.
- `rcon` out 8: round constant for the current round.
- `lastRound` out 1: current round is `NR`.
- `ctValid` out 1: datapath `cipher` byte valid this cycle.
- `done` out 1: single-cycle pulse with the last ciphertext byte.

## Operation
- FSM states: IDLE, LOAD, SR, SHIFT, OUT. Byte counter `cnt` is 4 bits and wraps 15→0. Round counter `rnd` is 4 bits, range 0..NR.
- IDLE: `ready`=1. If `start`=1, go to LOAD with `cnt`=0, `rnd`=0, `rcon`=8'h01.
- LOAD: `loadPT`=1, `keyEn`=1 for 16 cycles. At `cnt`=15, go to SR with `rnd`=1.
- SR: `doSR`=1 for one cycle, `keyEn`=0. Then go to SHIFT with `cnt`=0.
- SHIFT: `keyEn`=1 for 16 cycles.
  - `doMC`=1 when `cnt[1:0]`=0 and `rnd`≠NR (cnt 0, 4, 8, 12).
  - At `cnt`=15: if `rnd`=NR, go to OUT. Otherwise increment `rnd`, update `rcon` to xtime(`rcon`) (shift left; XOR 8'h1B if bit 7 was set), and go to SR.
- OUT: `ctValid`=1 and `keyEn`=1 for 16 cycles; this performs the final AddRoundKey while unloading. At `cnt`=15, `done`=1 and the FSM goes to IDLE.
- `rcon` sequence over rounds 1..10: 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36.
- `lastRound` = (`rnd`==NR) in SR, SHIFT and OUT.
- `start` outside IDLE is ignored. No queuing.
- All outputs are Moore: decoded from the registered state, `cnt`, `rnd` and `rcon`.

## Timing
- Reset values: state IDLE, `cnt`=0, `rnd`=0, `rcon`=8'h01. `ready`=1; `busy`, `en`, `loadPT`, `doSR`, `doMC`, `keyEn`, `lastRound`, `ctValid`, `done` all 0.
- With `start` sampled high at edge T:
  - LOAD occupies cycles T+1..T+16.
  - Round r SR is at T+17r. Round r SHIFT is at T+17r+1..T+17r+16.
  - Round 10 SHIFT ends at T+186.
  - OUT occupies T+187..T+202; `done` is at T+202.
  - `ready` is 1 at T+203.
- Total latency: 202 cycles from the first LOAD cycle to the last ciphertext byte.
- `doMC` is never asserted in the same cycle as `doSR`, `loadPT` or `ctValid`.
- `rst` mid-operation returns every register to its reset value immediately. There is no `done` pulse.
- `start` held high continuously: a new operation starts on the cycle after `done`, because IDLE is visited for exactly one cycle.

## Configuration
- `AES_CTRL_ABORT_EN` defined:
  - The `abort` port exists.
  - `abort`=1 in any non-IDLE state forces IDLE, `cnt`=0, `rnd`=0, `rcon`=8'h01 at the next edge. No `done` is issued.
  - `abort` has priority over all transitions. In IDLE it has no effect.
  - If `abort` and `start` are both high in IDLE, `start` wins.
- Not defined: no `abort` port, and operations always run to completion.

## Structure
- Shared package `aes_ctrl_pkg` holds:
  - state enum (IDLE, LOAD, SR, SHIFT, OUT);
  - `NR`/`NB` defaults;
  - `RCON_INIT` = 8'h01;
  - `RCON_POLY` = 8'h1B.
- One sub-module, `aes_rcon_gen`: an 8-bit register with init and step inputs that performs the xtime update and holds its value otherwise.
- The FSM, counters and output decode live in the top level.

## Test plan
- Reset then idle: `rst` pulse → all outputs at reset values, `ready`=1, `rcon`=01.
- Single encryption: `start` one cycle at T → `loadPT` high exactly T+1..T+16; 10 `doSR` pulses at T+17, 34, …, 170; `doMC` 36 times total (rounds 1-9, 4 per round), 0 in round 10; `ctValid` at T+187..T+202; `done` only at T+202.
- Round constants: sample `rcon` in each SHIFT phase → 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36; `lastRound`=1 only in round-10 SR/SHIFT and OUT.
- Ignored start and back-to-back operation: pulse `start` at T+50 → no effect. Hold `start` high → the second LOAD begins at T+204.
- Reset mid-operation: assert `rst` at T+100 → outputs return to reset values asynchronously; no `done`; a new `start` produces the full 202-cycle schedule again.
- Abort (`AES_CTRL_ABORT_EN`): `abort` at T+60 → IDLE at T+61 with `ready`=1 and no `done`. Then assert `start` and `abort` together in IDLE → the operation starts.

Source files
------------

// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the byte-serial AES-128 round controller.
package aes_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SR,
        SHIFT,
        OUT
    } ctrl_state_t;

    localparam int NR = 10;
    localparam int NB = 16;

    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [7:0] RCON_POLY = 8'h1B;

    localparam logic [3:0] NR_4      = 4'(NR);
    localparam logic [3:0] LAST_BYTE = 4'(NB - 1);

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// Round-constant register: reloads RCON_INIT on init, steps by xtime on step.
module aes_rcon_gen
    import aes_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       init,
    input  logic       step,
    output logic [7:0] rcon
);

    logic [7:0] rcon_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcon_reg <= RCON_INIT;
        end else if (init) begin
            rcon_reg <= RCON_INIT;
        end else if (step) begin
            rcon_reg <= xtime(rcon_reg);
        end
    end

    assign rcon = rcon_reg;

endmodule

// File: rtl/aes_serial_round_ctrl.sv
// Cycle sequencer for the byte-serial AES-128 datapath.
// Optional abort input is built when AES_CTRL_ABORT_EN is defined.
module aes_serial_round_ctrl
    import aes_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
`ifdef AES_CTRL_ABORT_EN
    input  logic       abort,
`endif
    output logic       ready,
    output logic       busy,
    output logic       en,
    output logic       loadPT,
    output logic       doSR,
    output logic       doMC,
    output logic       keyEn,
    output logic [7:0] rcon,
    output logic       lastRound,
    output logic       ctValid,
    output logic       done
);

    ctrl_state_t state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [3:0]  rnd_reg, rnd_next;
    logic        rcon_init, rcon_step;
    logic        abort_hit;
    logic        last_byte;

`ifdef AES_CTRL_ABORT_EN
    assign abort_hit = abort && (state_reg != IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    assign last_byte = (cnt_reg == LAST_BYTE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            rnd_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            rnd_reg   <= rnd_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        rnd_next   = rnd_reg;
        rcon_init  = 1'b0;
        rcon_step  = 1'b0;

        case (state_reg)
            IDLE: begin
                cnt_next  = 4'd0;
                rnd_next  = 4'd0;
                rcon_init = 1'b1;
                if (start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                cnt_next = cnt_reg + 4'd1;
                if (last_byte) begin
                    state_next = SR;
                    rnd_next   = 4'd1;
                end
            end
            SR: begin
                cnt_next   = 4'd0;
                state_next = SHIFT;
            end
            SHIFT: begin
                cnt_next = cnt_reg + 4'd1;
                if (last_byte) begin
                    if (rnd_reg == NR_4) begin
                        state_next = OUT;
                    end else begin
                        rnd_next   = rnd_reg + 4'd1;
                        rcon_step  = 1'b1;
                        state_next = SR;
                    end
                end
            end
            OUT: begin
                cnt_next = cnt_reg + 4'd1;
                if (last_byte) begin
                    state_next = IDLE;
                    rnd_next   = 4'd0;
                    rcon_init  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
                rnd_next   = 4'd0;
                rcon_init  = 1'b1;
            end
        endcase

        // Abort overrides whatever transition was chosen above.
        if (abort_hit) begin
            state_next = IDLE;
            cnt_next   = 4'd0;
            rnd_next   = 4'd0;
            rcon_init  = 1'b1;
            rcon_step  = 1'b0;
        end
    end

    aes_rcon_gen u_rcon_gen (
        .clk  (clk),
        .rst  (rst),
        .init (rcon_init),
        .step (rcon_step),
        .rcon (rcon)
    );

    always_comb begin
        ready     = (state_reg == IDLE);
        busy      = (state_reg != IDLE);
        en        = (state_reg != IDLE);
        loadPT    = (state_reg == LOAD);
        doSR      = (state_reg == SR);
        // The final round has no MixColumns.
        doMC      = (state_reg == SHIFT) && (cnt_reg[1:0] == 2'd0) && (rnd_reg != NR_4);
        keyEn     = (state_reg == LOAD) || (state_reg == SHIFT) || (state_reg == OUT);
        lastRound = ((state_reg == SR) || (state_reg == SHIFT) || (state_reg == OUT))
                    && (rnd_reg == NR_4);
        ctValid   = (state_reg == OUT);
        done      = (state_reg == OUT) && last_byte;
    end

endmodule
